// File: rtl/alu_operando_pkg.sv
// alu_operando_pkg: shared forward-select codes and immediate extension modes
// for the EX-stage operand source unit.
package alu_operando_pkg;
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEMWB  = 2'b01;
    localparam logic [1:0] FWD_EXMEM  = 2'b10;
    localparam logic [1:0] EXT_ZERO   = 2'd0;
    localparam logic [1:0] EXT_SIGN   = 2'd1;
    localparam logic [1:0] EXT_UPPER  = 2'd2;
    localparam logic [1:0] EXT_BRANCH = 2'd3;
endpackage

// File: rtl/alu_operando_fonte_fwd_select.sv
// fwd_select: picks one source operand from regfile, EX/MEM or MEM/WB;
// EX/MEM wins over MEM/WB and register 0 is never forwarded.
module fwd_select
    import alu_operando_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] regfile,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_resultado,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_resultado,
    output logic [DATA_W-1:0] valor,
    output logic [1:0]        sel
);
    logic ex_hit, mem_hit;

    always_comb begin
        ex_hit  = exmem_regwrite && exmem_rd == idx && idx != '0;
        mem_hit = memwb_regwrite && memwb_rd == idx && idx != '0;
        sel     = ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_REG;
        valor   = ex_hit ? exmem_resultado : mem_hit ? memwb_resultado : regfile;
    end
endmodule

// File: rtl/alu_operando_fonte.sv
// alu_operando_fonte: EX-stage operand source with forwarding, immediate
// extension and a registered pipeline slot (stall, flush, valid, fwd counter).
module alu_operando_fonte
    import alu_operando_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [IMM_W-1:0]  imediato,
    input  logic              controle,
    input  logic [1:0]        modo_ext,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_resultado,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_resultado,
    output logic [DATA_W-1:0] operando_a,
    output logic [DATA_W-1:0] saida_para_ALU,
    output logic [DATA_W-1:0] dado_store,
    output logic              valid_out,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  contador_fwd
);
    logic [DATA_W-1:0] val_a, val_b, zext, sext, imm_ext;
    logic [1:0]        sel_a, sel_b, fsel_b, inc;
    logic [CNT_W:0]    cnt_sum;
    logic              load;
    logic [DATA_W-1:0] op_a_d, op_a_q, op_b_d, op_b_q, store_d, store_q;
    logic              valid_d, valid_q;
    logic [1:0]        fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .idx(rs), .regfile(read_data1),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_resultado(memwb_resultado),
        .valor(val_a), .sel(sel_a)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .idx(rt), .regfile(read_data2),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_resultado(memwb_resultado),
        .valor(val_b), .sel(sel_b)
    );

    // Size casts keep the extender legal even when IMM_W == DATA_W.
    always_comb begin
        zext    = DATA_W'(imediato);
        sext    = DATA_W'($signed(imediato));
        imm_ext = modo_ext == EXT_ZERO  ? zext :
                  modo_ext == EXT_SIGN  ? sext :
                  modo_ext == EXT_UPPER ? zext << (DATA_W - IMM_W) :
                                          sext << 2;
        fsel_b  = controle ? FWD_REG : sel_b;
        inc     = {1'b0, sel_a != FWD_REG} + {1'b0, fsel_b != FWD_REG};
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(inc);
        load    = !flush && !stall;
        op_a_d  = load ? val_a : op_a_q;
        op_b_d  = load ? (controle ? imm_ext : val_b) : op_b_q;
        store_d = load ? val_b : store_q;
        valid_d = flush ? 1'b0 : stall ? valid_q : valid_in;
        fwd_a_d = flush ? FWD_REG : stall ? fwd_a_q : sel_a;
        fwd_b_d = flush ? FWD_REG : stall ? fwd_b_q : fsel_b;
        cnt_d   = !(load && valid_in) ? cnt_q : cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            store_q <= '0;
            valid_q <= 1'b0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
            cnt_q   <= '0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            store_q <= store_d;
            valid_q <= valid_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign operando_a     = op_a_q;
    assign saida_para_ALU = op_b_q;
    assign dado_store     = store_q;
    assign valid_out      = valid_q;
    assign fwd_a          = fwd_a_q;
    assign fwd_b          = fwd_b_q;
    assign contador_fwd   = cnt_q;
endmodule

// File: tb/tb_alu_operando_fonte.sv
// tb_alu_operando_fonte: directed checks of forwarding, extension, stall/flush,
// reset and counter saturation (second instance with a 2-bit counter).
module tb_alu_operando_fonte;
    logic        clk = 1'b0;
    logic        rst_n, valid_in, stall, flush, controle;
    logic        exmem_regwrite, memwb_regwrite;
    logic [31:0] read_data1, read_data2, exmem_resultado, memwb_resultado;
    logic [4:0]  rs, rt, exmem_rd, memwb_rd;
    logic [15:0] imediato;
    logic [1:0]  modo_ext;
    logic [31:0] operando_a, saida_para_ALU, dado_store;
    logic        valid_out;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] contador_fwd;
    logic [31:0] operando_a2, saida_para_ALU2, dado_store2;
    logic        valid_out2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  contador_fwd2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    alu_operando_fonte dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .read_data1(read_data1), .read_data2(read_data2), .rs(rs), .rt(rt),
        .imediato(imediato), .controle(controle), .modo_ext(modo_ext),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_resultado(memwb_resultado),
        .operando_a(operando_a), .saida_para_ALU(saida_para_ALU), .dado_store(dado_store),
        .valid_out(valid_out), .fwd_a(fwd_a), .fwd_b(fwd_b), .contador_fwd(contador_fwd)
    );

    alu_operando_fonte #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .read_data1(read_data1), .read_data2(read_data2), .rs(rs), .rt(rt),
        .imediato(imediato), .controle(controle), .modo_ext(modo_ext),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_resultado(memwb_resultado),
        .operando_a(operando_a2), .saida_para_ALU(saida_para_ALU2), .dado_store(dado_store2),
        .valid_out(valid_out2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .contador_fwd(contador_fwd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] st, input logic v, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [15:0] cnt);
        chk({tag, ".op_a"}, operando_a, a);
        chk({tag, ".op_b"}, saida_para_ALU, b);
        chk({tag, ".store"}, dado_store, st);
        chk({tag, ".valid"}, 32'(valid_out), 32'(v));
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
        chk({tag, ".cnt"}, 32'(contador_fwd), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; controle = 1'b0;
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0; read_data1 = '0; read_data2 = '0;
        exmem_resultado = '0; memwb_resultado = '0; rs = '0; rt = '0; exmem_rd = '0;
        memwb_rd = '0; imediato = '0; modo_ext = '0;
        #1 rst_n = 1'b0;
        #1 chk_all("reset0", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Immediate extension, no forwarding on rs=rt=0
        valid_in = 1'b1; controle = 1'b1; imediato = 16'h8004; read_data1 = 32'h0000_0111;
        read_data2 = 32'h0000_1234;
        modo_ext = 2'd0; tick; chk_all("ext00", 32'h111, 32'h0000_8004, 32'h1234, 1, 0, 0, 0);
        modo_ext = 2'd1; tick; chk("ext01", saida_para_ALU, 32'hFFFF_8004);
        modo_ext = 2'd2; tick; chk("ext10", saida_para_ALU, 32'h8004_0000);
        modo_ext = 2'd3; tick; chk("ext11", saida_para_ALU, 32'hFFFE_0010);

        // MEM/WB-only forward of rs, and of rt while controle=1 (fwd_b masked)
        rs = 5'd7; rt = 5'd7; memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_resultado = 32'h5555;
        modo_ext = 2'd0; tick;
        chk_all("memwb_imm", 32'h5555, 32'h0000_8004, 32'h5555, 1, 2'b01, 2'b00, 1);

        // EX/MEM beats MEM/WB on both operands
        rs = 5'd5; rt = 5'd5; controle = 1'b0; memwb_rd = 5'd5;
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_resultado = 32'hAAAA_0000;
        tick; chk_all("prio", 32'hAAAA_0000, 32'hAAAA_0000, 32'hAAAA_0000, 1, 2'b10, 2'b10, 3);

        // Stall freezes everything even though inputs would change outputs
        stall = 1'b1; exmem_resultado = 32'h1111_2222; valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; chk_all("stall", 32'hAAAA_0000, 32'hAAAA_0000, 32'hAAAA_0000, 1, 2'b10, 2'b10, 3);
        end
        flush = 1'b1;
        tick; chk_all("flush", 32'hAAAA_0000, 32'hAAAA_0000, 32'hAAAA_0000, 0, 0, 0, 3);
        stall = 1'b0; flush = 1'b0;

        // Register zero is never forwarded
        valid_in = 1'b1; rs = 5'd0; rt = 5'd3; read_data1 = '0; read_data2 = 32'h33;
        exmem_rd = 5'd0; exmem_resultado = 32'hDEAD_BEEF; memwb_rd = 5'd0;
        tick; chk_all("reg0", 0, 32'h33, 32'h33, 1, 0, 0, 3);

        // Bubble loads data but does not count
        valid_in = 1'b0; rs = 5'd9; exmem_rd = 5'd9;
        tick; chk_all("bubble", 32'hDEAD_BEEF, 32'h33, 32'h33, 0, 2'b10, 0, 3);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 chk_all("reset_mid", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_mid.cnt2", 32'(contador_fwd2), 0);
        @(negedge clk) rst_n = 1'b1;

        // Double-forward loads: 16-bit counter keeps climbing, 2-bit one saturates
        valid_in = 1'b1; controle = 1'b0; rs = 5'd4; rt = 5'd6;
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_resultado = 32'h4444;
        memwb_regwrite = 1'b1; memwb_rd = 5'd6; memwb_resultado = 32'h6666;
        tick; chk("sat1.cnt2", 32'(contador_fwd2), 2); chk("sat1.cnt", 32'(contador_fwd), 2);
        chk("sat1.fwd_b2", 32'(fwd_b2), 32'(2'b01)); chk("sat1.op_a2", operando_a2, 32'h4444);
        tick; chk("sat2.cnt2", 32'(contador_fwd2), 3); chk("sat2.cnt", 32'(contador_fwd), 4);
        tick; chk("sat3.cnt2", 32'(contador_fwd2), 3); chk("sat3.cnt", 32'(contador_fwd), 6);
        tick; chk("sat4.cnt2", 32'(contador_fwd2), 3); chk("sat4.cnt", 32'(contador_fwd), 8);
        chk("sat4.store", dado_store, 32'h6666);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
